// File: rtl/rpn_pkg.sv
// Shared opcode, error-code and FSM state definitions for the RPN sequencer.
package rpn_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_EQ  = 3'd5;

  localparam logic [1:0] ERR_OVF = 2'b01;
  localparam logic [1:0] ERR_UNF = 2'b10;
  localparam logic [1:0] ERR_ILL = 2'b11;

  typedef enum logic [3:0] {
    IDLE,
    PUSH,
    POP_A,
    POP_B,
    CALC,
    PUSH_R,
    WAIT_A,
    EMIT,
    ERR
  } state_t;

  // Opcodes 0..4 consume two stack entries and produce one.
  function automatic logic is_binary_op(input logic [2:0] op);
    return (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU for the RPN sequencer; A is top of stack, B is next on stack.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int STACK_WIDTH = 4
) (
  input  logic [STACK_WIDTH-1:0] A,
  input  logic [STACK_WIDTH-1:0] B,
  input  logic [2:0]             op,
  output logic [STACK_WIDTH-1:0] R
);

  // Results wrap modulo 2^STACK_WIDTH; SUB is NOS minus TOS.
  always_comb begin
    R = '0;
    case (op)
      OP_ADD:  R = B + A;
      OP_SUB:  R = B - A;
      OP_AND:  R = B & A;
      OP_OR:   R = B | A;
      OP_XOR:  R = B ^ A;
      default: R = '0;
    endcase
  end

endmodule

// File: rtl/rpn_sequencer.sv
// Token-driven RPN controller that owns the Push/Pop/Data_In side of an attached stack.
// Optional occupancy/flag cross-check enabled by defining RPN_STACK_CHECK_EN.
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter int STACK_WIDTH = 4
) (
  input  logic                   Clk,
  input  logic                   RstN,
  input  logic                   Tok_Valid,
  output logic                   Tok_Ready,
  input  logic                   Tok_IsOp,
  input  logic [STACK_WIDTH-1:0] Tok_Data,
  output logic                   Res_Valid,
  output logic [STACK_WIDTH-1:0] Res_Data,
  output logic                   Err,
  output logic [1:0]             Err_Code,
  output logic                   Stk_Push,
  output logic                   Stk_Pop,
  output logic [STACK_WIDTH-1:0] Stk_Data_In,
  input  logic [STACK_WIDTH-1:0] Stk_Data_Out,
  input  logic                   Stk_Full,
  input  logic                   Stk_Empty,
  output logic                   Sync_Err
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STACK_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

  state_t                 state;
  logic [CNT_W-1:0]       count;
  logic [2:0]             op_q;
  logic [STACK_WIDTH-1:0] a_q;
  logic [STACK_WIDTH-1:0] alu_r;
  logic [2:0]             tok_op;
  state_t                 acc_next;
  logic [1:0]             acc_code;

  assign tok_op = Tok_Data[2:0];

  // Decide the fate of the token presented in IDLE from the internal occupancy only.
  always_comb begin
    acc_next = PUSH;
    acc_code = ERR_OVF;
    if (!Tok_IsOp) begin
      if (count == DEPTH_C) begin
        acc_next = ERR;
        acc_code = ERR_OVF;
      end
    end else if (tok_op == OP_EQ) begin
      if (count == '0) begin
        acc_next = ERR;
        acc_code = ERR_UNF;
      end else begin
        acc_next = POP_A;
      end
    end else if (is_binary_op(tok_op)) begin
      if (count < TWO_C) begin
        acc_next = ERR;
        acc_code = ERR_UNF;
      end else begin
        acc_next = POP_A;
      end
    end else begin
      acc_next = ERR;
      acc_code = ERR_ILL;
    end
  end

  // B operand is the NOS value arriving on Stk_Data_Out during CALC.
  rpn_alu #(.STACK_WIDTH(STACK_WIDTH)) u_alu (
    .A  (a_q),
    .B  (Stk_Data_Out),
    .op (op_q),
    .R  (alu_r)
  );

  always_ff @(posedge Clk) begin
    if (state == POP_B) a_q <= Stk_Data_Out;
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state       <= IDLE;
      count       <= '0;
      op_q        <= OP_ADD;
      Tok_Ready   <= 1'b0;
      Res_Valid   <= 1'b0;
      Res_Data    <= '0;
      Err         <= 1'b0;
      Err_Code    <= 2'b00;
      Stk_Push    <= 1'b0;
      Stk_Pop     <= 1'b0;
      Stk_Data_In <= '0;
    end else begin
      Stk_Push  <= 1'b0;
      Stk_Pop   <= 1'b0;
      Res_Valid <= 1'b0;
      Err       <= 1'b0;
      Tok_Ready <= 1'b0;
      case (state)
        IDLE: begin
          if (Tok_Valid && Tok_Ready) begin
            op_q  <= tok_op;
            state <= acc_next;
            case (acc_next)
              PUSH: begin
                Stk_Push    <= 1'b1;
                Stk_Data_In <= Tok_Data;
              end
              POP_A:   Stk_Pop <= 1'b1;
              default: begin
                Err      <= 1'b1;
                Err_Code <= acc_code;
              end
            endcase
          end else begin
            Tok_Ready <= 1'b1;
          end
        end
        PUSH: begin
          count     <= count + ONE_C;
          state     <= IDLE;
          Tok_Ready <= 1'b1;
        end
        POP_A: begin
          if (op_q == OP_EQ) begin
            state <= WAIT_A;
          end else begin
            state   <= POP_B;
            Stk_Pop <= 1'b1;
          end
        end
        POP_B: state <= CALC;
        CALC: begin
          Stk_Data_In <= alu_r;
          Stk_Push    <= 1'b1;
          state       <= PUSH_R;
        end
        PUSH_R: begin
          count     <= count - ONE_C;
          state     <= IDLE;
          Tok_Ready <= 1'b1;
        end
        WAIT_A: begin
          Res_Data  <= Stk_Data_Out;
          Res_Valid <= 1'b1;
          state     <= EMIT;
        end
        EMIT: begin
          count     <= count - ONE_C;
          state     <= IDLE;
          Tok_Ready <= 1'b1;
        end
        ERR: begin
          state     <= IDLE;
          Tok_Ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RPN_STACK_CHECK_EN
  // Flags and counter settle together by the time the FSM is back in IDLE.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      Sync_Err <= 1'b0;
    end else if (state == IDLE &&
                 (((count == DEPTH_C) != Stk_Full) || ((count == '0) != Stk_Empty))) begin
      Sync_Err <= 1'b1;
    end
  end
`else
  logic unused_stack_flags;
  assign unused_stack_flags = Stk_Full ^ Stk_Empty;
  assign Sync_Err = 1'b0;
`endif

endmodule

// File: tb/tb_rpn_sequencer.sv
// Randomized bench for rpn_sequencer with a queue-based RPN reference model and a stack model.
module tb_rpn_sequencer;
  localparam int W = 4;
  localparam int D = 8;

  logic         Clk = 1'b0;
  logic         RstN = 1'b0;
  logic         Tok_Valid = 1'b0;
  logic         Tok_IsOp = 1'b0;
  logic [W-1:0] Tok_Data = '0;
  logic         Tok_Ready, Res_Valid, Err, Stk_Push, Stk_Pop, Stk_Full, Stk_Empty, Sync_Err;
  logic [W-1:0] Res_Data, Stk_Data_In, Stk_Data_Out;
  logic [1:0]   Err_Code;

  rpn_sequencer #(.STACK_DEPTH(D), .STACK_WIDTH(W)) dut (
    .Clk(Clk), .RstN(RstN), .Tok_Valid(Tok_Valid), .Tok_Ready(Tok_Ready),
    .Tok_IsOp(Tok_IsOp), .Tok_Data(Tok_Data), .Res_Valid(Res_Valid), .Res_Data(Res_Data),
    .Err(Err), .Err_Code(Err_Code), .Stk_Push(Stk_Push), .Stk_Pop(Stk_Pop),
    .Stk_Data_In(Stk_Data_In), .Stk_Data_Out(Stk_Data_Out), .Stk_Full(Stk_Full),
    .Stk_Empty(Stk_Empty), .Sync_Err(Sync_Err)
  );

  always #5 Clk = ~Clk;

  // Attached stack: registered Data_Out, flags from occupancy.
  logic [W-1:0] smem [D];
  int           sp;
  logic [W-1:0] sdout;
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      sp    <= 0;
      sdout <= '0;
    end else if (Stk_Push && sp < D) begin
      smem[sp] <= Stk_Data_In;
      sp       <= sp + 1;
    end else if (Stk_Pop && sp > 0) begin
      sdout <= smem[sp-1];
      sp    <= sp - 1;
    end
  end
  assign Stk_Full     = (sp == D);
  assign Stk_Empty    = (sp == 0);
  assign Stk_Data_Out = sdout;

  int n_push = 0, n_pop = 0, n_both = 0;
  always @(posedge Clk) begin
    if (Stk_Push) n_push <= n_push + 1;
    if (Stk_Pop) n_pop <= n_pop + 1;
    if (Stk_Push && Stk_Pop) n_both <= n_both + 1;
  end

  int total = 0, bad = 0;
  int q[$];
  int last_code = 0, last_res = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input bit isop, input int data);
    int exp_lat, exp_push, exp_pop, exp_err, exp_code, exp_res, exp_val;
    int a, b, r, n, lat, p0, o0, got_err, got_code, got_res, got_val, res_lat;
    exp_push = 0; exp_pop = 0; exp_err = 0; exp_code = 0; exp_res = 0; exp_val = 0;
    if (!isop) begin
      exp_lat = 2;
      if (q.size() == D) begin exp_err = 1; exp_code = 1; end
      else begin q.push_back(data & 15); exp_push = 1; end
    end else begin
      case (data & 7)
        5: begin
          if (q.size() == 0) begin exp_lat = 2; exp_err = 1; exp_code = 2; end
          else begin
            exp_lat = 4; exp_pop = 1; exp_res = 1; exp_val = q.pop_back();
          end
        end
        0, 1, 2, 3, 4: begin
          if (q.size() < 2) begin exp_lat = 2; exp_err = 1; exp_code = 2; end
          else begin
            a = q.pop_back(); b = q.pop_back();
            case (data & 7)
              0: r = (b + a) % 16;
              1: r = (b - a + 16) % 16;
              2: r = b & a;
              3: r = b | a;
              default: r = b ^ a;
            endcase
            q.push_back(r);
            exp_lat = 5; exp_pop = 2; exp_push = 1;
          end
        end
        default: begin exp_lat = 2; exp_err = 1; exp_code = 3; end
      endcase
    end
    if (exp_err) last_code = exp_code;
    if (exp_res) last_res = exp_val;

    n = 0;
    while (!Tok_Ready && n < 50) begin @(negedge Clk); n++; end
    chk("ready_wait", int'(Tok_Ready), 1);
    p0 = n_push; o0 = n_pop;
    Tok_Valid = 1'b1; Tok_IsOp = isop; Tok_Data = W'(data);
    @(posedge Clk); #1;
    Tok_Valid = 1'b0;
    lat = 0; got_err = 0; got_code = 0; got_res = 0; got_val = 0; res_lat = 0;
    do begin
      @(negedge Clk); lat++;
      if (Res_Valid) begin got_res++; got_val = int'(Res_Data); res_lat = lat; end
      if (Err) begin got_err++; got_code = int'(Err_Code); end
    end while (!Tok_Ready && lat < 20);
    chk("latency", lat, exp_lat);
    chk("push_cnt", n_push - p0, exp_push);
    chk("pop_cnt", n_pop - o0, exp_pop);
    chk("err_pulse", got_err, exp_err);
    chk("res_pulse", got_res, exp_res);
    if (exp_err) chk("err_code", got_code, exp_code);
    if (exp_res) begin
      chk("res_data", got_val, exp_val);
      chk("res_lat", res_lat, 3);
    end
    chk("err_code_held", int'(Err_Code), last_code);
    chk("res_data_held", int'(Res_Data), last_res);
    chk("empty", int'(Stk_Empty), int'(q.size() == 0));
    chk("full", int'(Stk_Full), int'(q.size() == D));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, int'(Tok_Ready), 0);
    chk({tag, "_res"}, int'({Res_Valid, Res_Data}), 0);
    chk({tag, "_err"}, int'({Err, Err_Code}), 0);
    chk({tag, "_stk"}, int'({Stk_Push, Stk_Pop, Stk_Data_In}), 0);
    chk({tag, "_sync"}, int'(Sync_Err), 0);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    chk_all_zero("reset");
    RstN = 1'b1;

    send(0, 3); send(0, 5); send(1, 0); send(1, 5);
    send(0, 2); send(0, 7); send(1, 1); send(1, 5);
    send(0, 15); send(0, 1); send(1, 0); send(1, 5);
    for (int i = 0; i < 8; i++) send(0, i);
    send(0, 9);
    for (int i = 0; i < 8; i++) send(1, 5);
    send(0, 4); send(1, 0); send(1, 5); send(1, 5);
    send(0, 3); send(1, 6); send(1, 7); send(1, 5);
    send(0, 12); send(0, 10); send(1, 4); send(1, 5);
    send(0, 12); send(0, 10); send(1, 2); send(1, 5);
    send(0, 12); send(0, 10); send(1, 3); send(1, 5);

    // Abort an ADD while it is in POP_B.
    send(0, 2); send(0, 3);
    while (!Tok_Ready) @(negedge Clk);
    Tok_Valid = 1'b1; Tok_IsOp = 1'b1; Tok_Data = W'(0);
    @(posedge Clk); #1;
    Tok_Valid = 1'b0;
    @(posedge Clk); #1;
    chk("pop_b_active", int'(Stk_Pop), 1);
    RstN = 1'b0;
    #1;
    chk_all_zero("midop");
    q.delete(); last_code = 0; last_res = 0;
    @(negedge Clk);
    RstN = 1'b1;
    send(0, 1); send(1, 5);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) send(0, int'($urandom_range(0, 15)));
      else send(1, int'($urandom_range(0, 15)));
    end
    while (q.size() > 0) send(1, 5);

    chk("push_pop_overlap", n_both, 0);
    chk("sync_err", int'(Sync_Err), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
